// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad row-scan controller: drives the row decoder select, samples the
// column lines once per row dwell, debounces whole-sweep results and reports
// each newly qualified key once over a valid/ready handshake.
module keypad_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 4,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] col,
  output logic [1:0] row_sel,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       overrun
);

  localparam int unsigned CntW  = $clog2(SCAN_DIV);
  localparam int unsigned StabW = $clog2(DEBOUNCE + 1);
  localparam logic [CntW-1:0]  CntLast = CntW'(SCAN_DIV - 1);
  localparam logic [StabW-1:0] StabMax = StabW'(DEBOUNCE);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StScan = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [1:0]       row_q, row_d;
  logic             cand_vld_q, cand_vld_d;
  logic [3:0]       cand_q, cand_d;
  logic             prev_vld_q, prev_vld_d;
  logic [3:0]       prev_q, prev_d;
  logic [StabW-1:0] stable_q, stable_d;
  logic             held_q, held_d;
  logic [3:0]       held_code_q, held_code_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             overrun_q, overrun_d;

  logic [1:0] col_idx;
  logic       sweep_vld;
  logic [3:0] sweep_code;
  logic       same;
  logic       qual;
  logic       accept;

  // Lowest set column bit of the current sample.
  always_comb begin
    col_idx = 2'd3;
    if (col[0])      col_idx = 2'd0;
    else if (col[1]) col_idx = 2'd1;
    else if (col[2]) col_idx = 2'd2;
  end

  // Dwell counting, sweep candidate tracking, debounce and handshake.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    row_d       = row_q;
    cand_vld_d  = cand_vld_q;
    cand_d      = cand_q;
    prev_vld_d  = prev_vld_q;
    prev_d      = prev_q;
    stable_d    = stable_q;
    held_d      = held_q;
    held_code_d = held_code_q;
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    overrun_d   = 1'b0;
    sweep_vld   = cand_vld_q;
    sweep_code  = cand_q;
    same        = 1'b0;
    qual        = 1'b0;
    accept      = 1'b0;

    if (!en) begin
      state_d     = StIdle;
      cnt_d       = '0;
      row_d       = 2'd0;
      cand_vld_d  = 1'b0;
      cand_d      = 4'd0;
      prev_vld_d  = 1'b0;
      prev_d      = 4'd0;
      stable_d    = '0;
      held_d      = 1'b0;
      held_code_d = 4'd0;
    end else if (state_q == StIdle) begin
      // Scan restarts at row 0; this edge is the first cycle of its dwell.
      state_d = StScan;
      cnt_d   = CntW'(1);
      row_d   = 2'd0;
    end else if (cnt_q != CntLast) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
      row_d = row_q + 2'd1;
      // First hit in row order wins; later rows in the same sweep are ignored.
      if (!cand_vld_q && (|col)) begin
        sweep_vld  = 1'b1;
        sweep_code = {row_q, col_idx};
      end
      if (row_q != 2'd3) begin
        cand_vld_d = sweep_vld;
        cand_d     = sweep_code;
      end else begin
        same     = (sweep_vld == prev_vld_q) && (!sweep_vld || (sweep_code == prev_q));
        stable_d = same ? ((stable_q == StabMax) ? StabMax : stable_q + 1'b1) : StabW'(1);
        // Qualification is the sweep on which the count first reaches the limit.
        qual       = (stable_d == StabMax) && (!same || (stable_q != StabMax));
        prev_vld_d = sweep_vld;
        prev_d     = sweep_vld ? sweep_code : 4'd0;
        cand_vld_d = 1'b0;
        cand_d     = 4'd0;
        if ((stable_d == StabMax) && !sweep_vld) begin
          held_d = 1'b0;
        end
        // A held key only blocks a re-report of the same key.
        if (qual && sweep_vld && (!held_q || (sweep_code != held_code_q))) begin
          accept      = 1'b1;
          held_d      = 1'b1;
          held_code_d = sweep_code;
        end
      end
    end

    if (key_valid_q && key_ready) begin
      key_valid_d = 1'b0;
    end
    // A key arriving on a transfer edge replaces the one being taken.
    if (accept) begin
      if (!key_valid_q || key_ready) begin
        key_valid_d = 1'b1;
        key_code_d  = sweep_code;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      row_q       <= 2'd0;
      cand_vld_q  <= 1'b0;
      cand_q      <= 4'd0;
      prev_vld_q  <= 1'b0;
      prev_q      <= 4'd0;
      stable_q    <= '0;
      held_q      <= 1'b0;
      held_code_q <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      cand_vld_q  <= cand_vld_d;
      cand_q      <= cand_d;
      prev_vld_q  <= prev_vld_d;
      prev_q      <= prev_d;
      stable_q    <= stable_d;
      held_q      <= held_d;
      held_code_q <= held_code_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign row_sel   = row_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a keypad model feeds col from row_sel, a
// negedge monitor records transfers and overrun pulses, and each scenario
// task compares the monitor's record against a queue of expected reports.
module tb_keypad_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] col;
  logic [1:0] row_sel;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready = 1'b0;
  logic       overrun;

  logic [3:0] keys [4];
  assign col = keys[row_sel];

  int cyc;
  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] exp_code [$];
  int         exp_cyc [$];
  logic [3:0] obs_code [$];
  int         obs_cyc [$];
  int         ovr_cnt;
  int         ovr_cyc;

  keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .col       (col),
    .row_sel   (row_sel),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Edge counter since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Monitor: record delivered keys and overrun pulses mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      obs_code.delete();
      obs_cyc.delete();
      ovr_cnt = 0;
      ovr_cyc = -1;
    end else begin
      if (key_valid && key_ready) begin
        obs_code.push_back(key_code);
        obs_cyc.push_back(cyc);
      end
      if (overrun) begin
        ovr_cnt++;
        ovr_cyc = cyc;
      end
    end
  end

  task automatic do_reset(input logic en_v, input logic rdy_v);
    for (int r = 0; r < 4; r++) keys[r] = 4'd0;
    en        = en_v;
    key_ready = rdy_v;
    rst_n     = 1'b0;
    exp_code.delete();
    exp_cyc.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    do_reset(1'b1, 1'b1);
    n_cmp++;
    if (overrun !== 1'b0 || key_valid !== 1'b0 || key_code !== 4'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b c=%h o=%b want 0,0,0", key_valid, key_code, overrun);
    end
    for (int k = 0; k < 40; k++) begin
      wait_until(k);
      n_cmp++;
      if (row_sel !== 2'((k / 4) % 4)) begin
        n_err++;
        $display("FAIL reset_row_seq cyc %0d: got %0d want %0d", k, row_sel, (k / 4) % 4);
      end
      n_cmp++;
      if (key_valid !== 1'b0 || overrun !== 1'b0 || key_code !== 4'd0) begin
        n_err++;
        $display("FAIL reset_idle_out cyc %0d: got v=%b o=%b c=%h want 0", k, key_valid, overrun,
                 key_code);
      end
    end
  endtask

  task automatic test_press;
    do_reset(1'b1, 1'b1);
    keys[2] = 4'b0010;
    exp_code.push_back(4'h9);
    exp_cyc.push_back(48);
    wait_until(47);
    n_cmp++;
    if (key_valid !== 1'b0) begin
      n_err++;
      $display("FAIL press_early: got valid=%b want 0 at cyc 47", key_valid);
    end
    wait_until(112);
    n_cmp++;
    if (obs_code.size() != exp_code.size()) begin
      n_err++;
      $display("FAIL press_count: got %0d reports want %0d", obs_code.size(), exp_code.size());
    end
    while (exp_code.size() > 0 && obs_code.size() > 0) begin
      logic [3:0] ec, oc;
      int         et, ot;
      ec = exp_code.pop_front(); et = exp_cyc.pop_front();
      oc = obs_code.pop_front(); ot = obs_cyc.pop_front();
      n_cmp++;
      if (oc !== ec || ot != et) begin
        n_err++;
        $display("FAIL press_report: got %h@%0d want %h@%0d", oc, ot, ec, et);
      end
    end
    n_cmp++;
    if (ovr_cnt != 0) begin
      n_err++;
      $display("FAIL press_overrun: got %0d pulses want 0", ovr_cnt);
    end
  endtask

  // Continues from test_press: key still down at cyc 112.
  task automatic test_release_repress;
    for (int r = 0; r < 4; r++) keys[r] = 4'd0;
    wait_until(160);
    keys[2] = 4'b0010;
    exp_code.push_back(4'h9);
    exp_cyc.push_back(208);
    wait_until(240);
    n_cmp++;
    if (obs_code.size() != exp_code.size()) begin
      n_err++;
      $display("FAIL repress_count: got %0d reports want %0d", obs_code.size(), exp_code.size());
    end
    while (exp_code.size() > 0 && obs_code.size() > 0) begin
      logic [3:0] ec, oc;
      int         et, ot;
      ec = exp_code.pop_front(); et = exp_cyc.pop_front();
      oc = obs_code.pop_front(); ot = obs_cyc.pop_front();
      n_cmp++;
      if (oc !== ec || ot != et) begin
        n_err++;
        $display("FAIL repress_report: got %h@%0d want %h@%0d", oc, ot, ec, et);
      end
    end
    // Released for 3 sweeps, then key in sweeps 1 and 3 only.
    keys[2] = 4'd0;
    wait_until(288);
    keys[2] = 4'b0010;
    wait_until(304);
    keys[2] = 4'd0;
    wait_until(320);
    keys[2] = 4'b0010;
    wait_until(336);
    keys[2] = 4'd0;
    wait_until(400);
    n_cmp++;
    if (obs_code.size() != 0) begin
      n_err++;
      $display("FAIL glitch_no_report: got %0d reports want 0", obs_code.size());
    end
  endtask

  task automatic test_priority;
    do_reset(1'b1, 1'b1);
    keys[1] = 4'b0001;
    keys[2] = 4'b1000;
    exp_code.push_back(4'h4);
    exp_cyc.push_back(48);
    wait_until(48);
    // Direct change to a different key qualifies while still held.
    keys[1] = 4'd0;
    keys[2] = 4'd0;
    keys[0] = 4'b1010;
    exp_code.push_back(4'h1);
    exp_cyc.push_back(96);
    wait_until(112);
    n_cmp++;
    if (obs_code.size() != exp_code.size()) begin
      n_err++;
      $display("FAIL prio_count: got %0d reports want %0d", obs_code.size(), exp_code.size());
    end
    while (exp_code.size() > 0 && obs_code.size() > 0) begin
      logic [3:0] ec, oc;
      int         et, ot;
      ec = exp_code.pop_front(); et = exp_cyc.pop_front();
      oc = obs_code.pop_front(); ot = obs_cyc.pop_front();
      n_cmp++;
      if (oc !== ec || ot != et) begin
        n_err++;
        $display("FAIL prio_report: got %h@%0d want %h@%0d", oc, ot, ec, et);
      end
    end
  endtask

  task automatic test_overrun;
    do_reset(1'b1, 1'b0);
    keys[2] = 4'b0010;
    wait_until(48);
    keys[2] = 4'd0;
    keys[1] = 4'b0001;
    wait_until(100);
    n_cmp++;
    if (ovr_cnt != 1 || ovr_cyc != 96) begin
      n_err++;
      $display("FAIL overrun_pulse: got %0d pulses last@%0d want 1@96", ovr_cnt, ovr_cyc);
    end
    n_cmp++;
    if (key_valid !== 1'b1 || key_code !== 4'h9) begin
      n_err++;
      $display("FAIL overrun_keep: got v=%b c=%h want 1,9", key_valid, key_code);
    end
    exp_code.push_back(4'h9);
    exp_cyc.push_back(100);
    key_ready = 1'b1;
    wait_until(101);
    n_cmp++;
    if (key_valid !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_xfer_drop: got valid=%b want 0", key_valid);
    end
    wait_until(140);
    n_cmp++;
    if (obs_code.size() != exp_code.size()) begin
      n_err++;
      $display("FAIL overrun_count: got %0d reports want %0d", obs_code.size(), exp_code.size());
    end
    while (exp_code.size() > 0 && obs_code.size() > 0) begin
      logic [3:0] ec, oc;
      int         et, ot;
      ec = exp_code.pop_front(); et = exp_cyc.pop_front();
      oc = obs_code.pop_front(); ot = obs_cyc.pop_front();
      n_cmp++;
      if (oc !== ec || ot != et) begin
        n_err++;
        $display("FAIL overrun_report: got %h@%0d want %h@%0d", oc, ot, ec, et);
      end
    end
  endtask

  task automatic test_reset_and_enable;
    do_reset(1'b1, 1'b0);
    keys[2] = 4'b0010;
    wait_until(56);
    n_cmp++;
    if (key_valid !== 1'b1 || key_code !== 4'h9) begin
      n_err++;
      $display("FAIL pend_before_rst: got v=%b c=%h want 1,9", key_valid, key_code);
    end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (key_valid !== 1'b0 || key_code !== 4'd0 || row_sel !== 2'd0 || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL async_rst: got v=%b c=%h r=%0d o=%b want all 0", key_valid, key_code,
               row_sel, overrun);
    end
    do_reset(1'b1, 1'b1);
    wait_until(9);
    n_cmp++;
    if (row_sel !== 2'd2) begin
      n_err++;
      $display("FAIL en_pre_row: got %0d want 2", row_sel);
    end
    en = 1'b0;
    wait_until(10);
    n_cmp++;
    if (row_sel !== 2'd0) begin
      n_err++;
      $display("FAIL en_off_row: got %0d want 0", row_sel);
    end
    wait_until(13);
    n_cmp++;
    if (row_sel !== 2'd0) begin
      n_err++;
      $display("FAIL idle_row: got %0d want 0", row_sel);
    end
    en = 1'b1;
    for (int j = 0; j < 20; j++) begin
      wait_until(13 + j);
      n_cmp++;
      if (row_sel !== 2'((j / 4) % 4)) begin
        n_err++;
        $display("FAIL reen_row_seq +%0d: got %0d want %0d", j, row_sel, (j / 4) % 4);
      end
    end
  endtask

  initial begin
    for (int r = 0; r < 4; r++) keys[r] = 4'd0;
    test_reset();
    test_press();
    test_release_repress();
    test_priority();
    test_overrun();
    test_reset_and_enable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Upstream row-scan controller for a 4x4 keypad. It drives the 2-bit select into the existing 2-to-4 row decoder, and that decoder's one-hot outputs energise one keypad row at a time. The block samples the four column lines for each row, debounces the result across full sweeps, and delivers each new key press once as a 4-bit code over a valid/ready handshake.

## Interface
Parameters:
- SCAN_DIV, 4: clock cycles each row is held selected. Minimum 2.
- DEBOUNCE, 3: number of consecutive identical sweep results needed to accept a press or a release. Minimum 1.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- en  in  1  scan enable.
- col  in  4  column lines, active-high; bit i is column i.
- row_sel  out  2  row index to the decoder: row_sel[1] drives decoder input a, row_sel[0] drives b.
- key_code  out  4  {row[1:0], col[1:0]} of the reported key.
- key_valid  out  1  key_code holds an undelivered key.
- key_ready  in  1  consumer accepts key_code.
- overrun  out  1  one-cycle pulse when a qualified key is dropped.

## Operation
- Reset values: row_sel=0, key_code=0, key_valid=0, overrun=0. Dwell counter, sweep candidate, previous candidate (set to "none"), stable count and held flag are all cleared.
- Scan FSM states:
  - IDLE: entered when en=0. row_sel is forced to 0; dwell counter, candidates, stable count and held flag are cleared. A pending key_valid/key_code is kept until it is accepted.
  - SCAN: entered when en=1. A new scan starts at row 0 with the dwell count at 0.
- Dwell behaviour, in SCAN each cycle:
  - If cnt < SCAN_DIV-1: cnt increments.
  - If cnt == SCAN_DIV-1: col is sampled for the current row, cnt returns to 0, and row_sel advances by 1, wrapping from 3 to 0.
- Candidate selection within a sweep: the first row in order 0..3 with any col bit high wins. Within that row, the lowest set col bit wins. Later hits in the same sweep are ignored.
- Sweep end is the row-3 sample edge. On that edge:
  - The candidate (a key code or "none") is compared with the previous candidate.
  - If they are equal, the stable count increments, saturating at DEBOUNCE. If they differ, the stable count becomes 1.
  - The candidate becomes the new previous candidate and the sweep candidate resets to "none".
- Press accept: stable count reaches DEBOUNCE, the candidate is a key, and held=0. Then held is set to 1 and:
  - if key_valid=0: key_code is loaded with the candidate and key_valid is set to 1;
  - if key_valid=1: the key is dropped, key_code is unchanged, and overrun pulses.
- Release: stable count reaches DEBOUNCE with candidate "none", which clears held. A key held down therefore reports exactly once.
- A change from one key directly to a different key counts as a new candidate. It qualifies after DEBOUNCE sweeps even if held=1, and held stays 1.
- Handshake: a transfer occurs on an edge where key_valid & key_ready. key_valid falls on that edge unless a new key is loaded on the same edge, in which case the new key wins and key_valid stays 1. key_code must not change while key_valid=1 and no transfer occurs.

## Timing
- Each row is selected for SCAN_DIV cycles. One sweep is 4*SCAN_DIV cycles. col is sampled in the last cycle of each row's dwell, which gives settling time.
- key_valid is registered: it is visible in the cycle after the accepting sweep-end edge.
- Minimum press latency is DEBOUNCE sweeps measured from the first sweep that sees the key.
- en falling takes effect on the next edge: row_sel reads 0 one cycle later.
- rst_n low clears all state immediately, mid-sweep or otherwise, including a pending key.
- key_ready is ignored while key_valid=0.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE=3.
- Reset release with en=1 and col=0 -> row_sel reads 0,0,0,0,1,1,1,1,2,… and wraps 3→0 every 16 cycles. key_valid, overrun and key_code stay 0.
- col=4'b0010 whenever row_sel==2, key_ready=1 -> key_valid high for exactly one cycle after the 3rd sweep end (cycle 48), with key_code=4'h9. No repeat report while the key remains pressed.
- Release for 3 sweeps, then press row 2 col 1 again for 3 sweeps -> second report of 4'h9. The key present in sweeps 1 and 3 but absent in sweep 2 -> no report.
- Keys at row 1 col 0 and row 2 col 3 pressed together -> key_code=4'h4. col=4'b1010 on row 0 -> key_code=4'h1.
- key_ready=0 with key 4'h9 pending, then key 4'h4 qualifies -> one-cycle overrun pulse, key_code stays 4'h9. key_ready=1 -> transfer, and key_valid is 0 in the next cycle.
- rst_n pulsed low mid-sweep while key_valid=1 -> all outputs 0 immediately. en=0 during row 2 -> row_sel=0 on the next cycle. Re-enabling -> the scan restarts at row 0 with a full 4-cycle dwell.
